// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// fetch_buf: circular instruction buffer with flush; head entry read straight from storage.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; a push into a full buffer is refused.
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && (count != '0);

  assign full = (count == CNT_W'(DEPTH));
  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch front end with redirect, discard and fault handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fetch_fault
);

  // state | meaning
  // REQ   | drive a fetch request at fetch_pc when the buffer has room
  // WAIT  | one request outstanding; its response is pushed, or dropped if discard_pending
  // HALT  | misaligned redirect taken; no requests until an aligned redirect

  localparam int          CNT_W            = $clog2(BUF_DEPTH) + 1;
  localparam int          ENTRY_W          = 32 + INSTR_W;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t       state;
  logic [31:0]        fetch_pc;
  logic [31:0]        inflight_pc;
  logic               discard_pending;

  logic [CNT_W-1:0]   buf_count;
  logic               buf_full;
  logic [ENTRY_W-1:0] buf_head;
  logic               buf_push;
  logic               buf_pop;

  logic               req_fire;
  logic               rsp_take;
  logic               redirect_ok;
  logic               still_outstanding;

  // In REQ nothing is outstanding, so the occupancy bound reduces to "buffer not full".
  assign imem_req_valid = !rst && (state == ST_REQ) && !buf_full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are only meaningful in WAIT; anything else on the bus is ignored.
  assign rsp_take    = (state == ST_WAIT) && imem_rsp_valid;
  assign redirect_ok = redirect_valid && is_aligned(redirect_pc);

  // A response consumed this cycle closes the outstanding request even if it is dropped,
  // so only a still-open WAIT or a request accepted this cycle leaves something in flight.
  assign still_outstanding = ((state == ST_WAIT) && !imem_rsp_valid) || req_fire;

  assign buf_push = rsp_take && !discard_pending && !redirect_valid;
  assign buf_pop  = out_valid && out_ready;

  assign out_valid = (buf_count != '0);
  assign out_pc    = buf_head[ENTRY_W-1:INSTR_W];
  assign out_instr = buf_head[INSTR_W-1:0];

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data ({inflight_pc, imem_rsp_data}),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .full      (buf_full),
    .count     (buf_count),
    .head      (buf_head)
  );

  // Fetch sequencing: reset, then redirects, then the normal request/response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A request left in flight across reset must still be drained before new requests,
      // otherwise two would be outstanding; park in WAIT with the discard flag set.
      fetch_pc        <= RESET_PC_ALIGNED;
      inflight_pc     <= '0;
      fetch_fault     <= 1'b0;
      discard_pending <= (state == ST_WAIT) && !imem_rsp_valid;
      state           <= ((state == ST_WAIT) && !imem_rsp_valid) ? ST_WAIT : ST_REQ;
    end else if (redirect_valid) begin
      if (redirect_ok) begin
        fetch_pc    <= redirect_pc;
        fetch_fault <= 1'b0;
      end else begin
        fetch_fault <= 1'b1;
      end
      if (still_outstanding) begin
        discard_pending <= 1'b1;
        state           <= ST_WAIT;
      end else begin
        discard_pending <= 1'b0;
        state           <= redirect_ok ? ST_REQ : ST_HALT;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            discard_pending <= 1'b0;
            state           <= fetch_fault ? ST_HALT : ST_REQ;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios against a transaction-level fetch model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  int checks = 0;
  int errors = 0;

  // memory model state
  int          mem_lat = 0;
  int          fire_cnt = 0;
  logic        pending = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] pend_addr = '0;

  // reference model state
  logic [31:0] exp_pc;
  logic        exp_fault;
  logic [31:0] pop_log [256];
  int          pop_n = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: always ready, answers each accepted request after mem_lat extra cycles.
  initial begin
    logic        fire;
    logic [31:0] faddr;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire  = imem_req_valid && imem_req_ready;
      faddr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (fire) begin
        fire_cnt++;
        check("one_outstanding", {31'b0, pending}, 32'd0);
        pending   = 1'b1;
        pend_addr = faddr;
        wait_cnt  = mem_lat;
      end else if (pending && wait_cnt > 0) begin
        wait_cnt--;
      end
      if (pending && wait_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(pend_addr);
        pending        = 1'b0;
      end
    end
  end

  // Compare process: delivered instructions must be consecutive words from the last
  // reset or aligned redirect target; fault state follows the redirect history.
  initial begin
    exp_pc    = RST_PC;
    exp_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("req_in_reset", {31'b0, imem_req_valid}, 32'd0);
      end else begin
        check("fault_state", {31'b0, fetch_fault}, {31'b0, exp_fault});
        if (exp_fault) check("req_while_fault", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) check("req_align", {30'b0, imem_req_addr[1:0]}, 32'd0);
        if (out_valid && out_ready && !redirect_valid) begin
          check("out_pc", out_pc, exp_pc);
          check("out_instr", out_instr, mem_fn(exp_pc));
          if (pop_n < 256) pop_log[pop_n] = out_pc;
          pop_n++;
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (rst) begin
        exp_pc    = RST_PC;
        exp_fault = 1'b0;
      end else if (redirect_valid) begin
        if (redirect_pc[1:0] == 2'b00) begin
          exp_pc    = redirect_pc;
          exp_fault = 1'b0;
        end else begin
          exp_fault = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_stream [6];
    int          p0;
    int          f0;
    logic        ok;
    exp_stream = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
                   32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    mem_lat        = 0;

    // reset state
    tick();
    tick();
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_pc", out_pc, 32'd0);
    check("reset_out_instr", out_instr, 32'd0);
    check("reset_fault", {31'b0, fetch_fault}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, RST_PC);

    // streaming across the 32-bit wrap
    ok = 1'b0;
    for (int g = 0; g < 80; g++) begin
      tick();
      if (pop_n >= 6) begin ok = 1'b1; break; end
    end
    check("stream_wait", {31'b0, ok}, 32'd1);
    for (int i = 0; i < 6; i++) check("stream_pc", pop_log[i], exp_stream[i]);

    // backpressure: refill from 0x40 with decode stalled
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    f0 = fire_cnt;
    repeat (6) tick();
    check("full_no_req", 32'(fire_cnt), 32'(f0));
    @(negedge clk);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("full_head_pc", out_pc, 32'h0000_0040);
    p0 = pop_n;
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    check("bp_pop_count", 32'(pop_n - p0), 32'd4);
    check("bp_first", pop_log[p0], 32'h0000_0040);
    check("bp_last", pop_log[p0 + 3], 32'h0000_004C);

    // redirect while a request is outstanding
    tick();
    mem_lat        = 3;
    p0             = pop_n;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    tick();
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (pending && pend_addr == 32'h0000_0008) begin ok = 1'b1; break; end
    end
    check("wait_on_8", {31'b0, ok}, 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (pop_n >= p0 + 3) begin ok = 1'b1; break; end
    end
    check("redir_wait", {31'b0, ok}, 32'd1);
    check("redir_pc0", pop_log[p0], 32'h0000_0000);
    check("redir_pc1", pop_log[p0 + 1], 32'h0000_0004);
    check("redir_target", pop_log[p0 + 2], 32'h0000_0100);

    // misaligned redirect halts fetch, aligned redirect recovers
    mem_lat = 0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    f0 = fire_cnt;
    repeat (8) tick();
    check("halt_no_fire", 32'(fire_cnt), 32'(f0));
    @(negedge clk);
    check("halt_fault", {31'b0, fetch_fault}, 32'd1);
    check("halt_out_valid", {31'b0, out_valid}, 32'd0);
    check("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
    p0 = pop_n;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 60; g++) begin
      tick();
      if (pop_n > p0) begin ok = 1'b1; break; end
    end
    check("recover_wait", {31'b0, ok}, 32'd1);
    check("recover_pc", pop_log[p0], 32'h0000_0200);
    @(negedge clk);
    check("recover_fault", {31'b0, fetch_fault}, 32'd0);

    // reset while a request is outstanding; its late response must be dropped
    tick();
    out_ready = 1'b0;
    mem_lat   = 4;
    ok = 1'b0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (pending) begin ok = 1'b1; break; end
    end
    check("wait_outstanding", {31'b0, ok}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    mem_lat   = 0;
    out_ready = 1'b1;
    p0        = pop_n;
    ok = 1'b0;
    for (int g = 0; g < 60; g++) begin
      tick();
      if (pop_n > p0) begin ok = 1'b1; break; end
    end
    check("rst_wait", {31'b0, ok}, 32'd1);
    check("rst_first_pc", pop_log[p0], RST_PC);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
